// File: rtl/mem_pkg.sv
// Shared types for the MIPS memory-access stage: access-size encodings and the
// MEM/WB pipeline register layout.
package mem_pkg;

  localparam int XLEN      = 32;
  localparam int NUM_LANES = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] ReadData;
    logic [XLEN-1:0] ALUOut;
    logic            RegWrite;
    logic            MemToReg;
    logic [4:0]      WriteReg;
  } mem_wb_t;

  // Encoding 11 behaves as a word access, so anything not byte/half needs a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half out of a little-endian memory word and
// sign- or zero-extends it to the full datapath width.
module load_extend
  import mem_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [1:0]      mem_size,
  input  logic            mem_signed,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (mem_size)
      SZ_BYTE: data = {{24{mem_signed & byte_sel[7]}}, byte_sel};
      SZ_HALF: data = {{16{mem_signed & half_sel[15]}}, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: byte-enabled data memory, alignment checking and
// the MEM/WB pipeline register.
module mem_stage
  import mem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [1:0]       MemSize,
  input  logic             MemSigned,
  input  logic [WIDTH-1:0] ALUOut,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             RegWrite_in,
  input  logic [4:0]       WriteReg_in,
  input  logic             stall,
  input  logic             flush,
  output logic             valid_out,
  output logic [WIDTH-1:0] ReadData,
  output logic [WIDTH-1:0] ALUOut_q,
  output logic             RegWrite_out,
  output logic             MemToReg_out,
  output logic [4:0]       WriteReg_out,
  output logic             misaligned
);

  localparam int AW = $clog2(DEPTH);

  logic [NUM_LANES-1:0][7:0] mem [DEPTH];

  logic [AW-1:0]             idx;
  logic [1:0]                off;
  logic                      fault, bubble, we;
  logic [NUM_LANES-1:0]      be;
  logic [NUM_LANES-1:0][7:0] wlanes;
  logic [WIDTH-1:0]          rword, ext;
  mem_wb_t                   wb_q, wb_d;
  logic                      mis_q, mis_d;

  assign idx    = ALUOut[AW+1:2];
  assign off    = ALUOut[1:0];
  assign fault  = valid_in & (MemRead | MemWrite) & is_misaligned(MemSize, off);
  assign bubble = flush | ~valid_in;
  assign we     = valid_in & MemWrite & ~fault & ~stall & ~flush & ~rst;

  // Store data is replicated across lanes so each lane only needs its enable.
  always_comb begin
    case (MemSize)
      SZ_BYTE: wlanes = {4{WriteData[7:0]}};
      SZ_HALF: wlanes = {2{WriteData[15:0]}};
      default: wlanes = WriteData;
    endcase
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    localparam logic [1:0] LANE = 2'(k);
    assign be[k] = (MemSize == SZ_BYTE) ? (off == LANE) :
                   (MemSize == SZ_HALF) ? (off[1] == LANE[1]) : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (be[k]) mem[idx][k] <= wlanes[k];
      end
    end
  end

  assign rword = mem[idx];

  load_extend u_load_extend (
    .word       (rword),
    .offset     (off),
    .mem_size   (MemSize),
    .mem_signed (MemSigned),
    .data       (ext)
  );

  // Bubble beats stall; a stall holds everything except the fault pulse.
  always_comb begin
    wb_d  = wb_q;
    mis_d = 1'b0;
    if (bubble) begin
      wb_d = '0;
    end else if (!stall) begin
      wb_d.valid    = 1'b1;
      wb_d.ReadData = (MemRead & ~fault) ? ext : '0;
      wb_d.ALUOut   = ALUOut;
      wb_d.RegWrite = RegWrite_in & ~fault;
      wb_d.MemToReg = MemRead & ~fault;
      wb_d.WriteReg = WriteReg_in;
      mis_d         = fault;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q  <= '0;
      mis_q <= 1'b0;
    end else begin
      wb_q  <= wb_d;
      mis_q <= mis_d;
    end
  end

  assign valid_out    = wb_q.valid;
  assign ReadData     = wb_q.ReadData;
  assign ALUOut_q     = wb_q.ALUOut;
  assign RegWrite_out = wb_q.RegWrite;
  assign MemToReg_out = wb_q.MemToReg;
  assign WriteReg_out = wb_q.WriteReg;
  assign misaligned   = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized run
// against a byte-array reference model.
module tb_mem_stage;

  localparam int DEPTH = 256;
  localparam int BYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst, valid_in, MemRead, MemWrite, MemSigned, RegWrite_in, stall, flush;
  logic [1:0]  MemSize;
  logic [31:0] ALUOut, WriteData;
  logic [4:0]  WriteReg_in;
  logic        valid_out, RegWrite_out, MemToReg_out, misaligned;
  logic [31:0] ReadData, ALUOut_q;
  logic [4:0]  WriteReg_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  ref_mem [BYTES];
  logic        e_valid, e_rw, e_m2r, e_mis, e_chk_rd, e_chk_alu;
  logic [31:0] e_rd, e_alu;
  logic [4:0]  e_wr;

  always #5 clk = ~clk;

  mem_stage #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemSize(MemSize), .MemSigned(MemSigned), .ALUOut(ALUOut), .WriteData(WriteData),
    .RegWrite_in(RegWrite_in), .WriteReg_in(WriteReg_in), .stall(stall), .flush(flush),
    .valid_out(valid_out), .ReadData(ReadData), .ALUOut_q(ALUOut_q),
    .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
    .WriteReg_out(WriteReg_out), .misaligned(misaligned)
  );

  function automatic int eff_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic m_fault();
    int n = eff_bytes(MemSize);
    return valid_in && (MemRead || MemWrite) && ((ALUOut % n) != 0);
  endfunction

  function automatic logic [31:0] m_load();
    int base = int'(ALUOut % BYTES);
    int n = eff_bytes(MemSize);
    logic [31:0] v = 0;
    for (int i = 0; i < n; i++) v = v + (32'(ref_mem[base + i]) << (8 * i));
    if (MemSigned && n == 1 && v[7])  v = v + 32'hFFFFFF00;
    if (MemSigned && n == 2 && v[15]) v = v + 32'hFFFF0000;
    return v;
  endfunction

  task automatic drive(input logic v, rd, wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, d, input logic rw, input logic [4:0] wreg,
                       input logic st, fl);
    valid_in = v; MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sg;
    ALUOut = a; WriteData = d; RegWrite_in = rw; WriteReg_in = wreg; stall = st; flush = fl;
  endtask

  // Advance one clock; the reference model updates from the inputs sampled at the edge.
  task automatic tick();
    logic f = m_fault();
    logic do_wr = !rst && valid_in && MemWrite && !f && !stall && !flush;
    logic [31:0] ld = m_load();
    int base = int'(ALUOut % BYTES);
    int n = eff_bytes(MemSize);
    @(posedge clk);
    #1;
    if (do_wr) for (int i = 0; i < n; i++) ref_mem[base + i] = WriteData[8*i +: 8];
    if (rst) begin
      {e_valid, e_rw, e_m2r, e_mis, e_rd, e_alu, e_wr} = '0;
      e_chk_rd = 1; e_chk_alu = 1;
    end else if (flush || !valid_in) begin
      {e_valid, e_rw, e_m2r, e_mis} = '0;
      e_chk_rd = 0; e_chk_alu = 0;
    end else if (stall) begin
      e_mis = 0;
    end else begin
      e_valid = 1; e_alu = ALUOut; e_wr = WriteReg_in;
      e_rw = RegWrite_in && !f; e_m2r = MemRead && !f; e_mis = f;
      e_rd = (MemRead && !f) ? ld : 32'h0;
      e_chk_alu = 1; e_chk_rd = !(MemRead && f);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    drive(1, 1, 0, 2'd2, 0, 32'h0, 32'h0, 1, 5'd3, 0, 0);
    tick();
    n_cmp += 7;
    if (valid_out !== 1'b0)     begin n_bad++; $display("FAIL reset_valid got %h want 0", valid_out); end
    if (ReadData !== 32'h0)     begin n_bad++; $display("FAIL reset_rd got %h want 0", ReadData); end
    if (ALUOut_q !== 32'h0)     begin n_bad++; $display("FAIL reset_alu got %h want 0", ALUOut_q); end
    if (RegWrite_out !== 1'b0)  begin n_bad++; $display("FAIL reset_rw got %h want 0", RegWrite_out); end
    if (MemToReg_out !== 1'b0)  begin n_bad++; $display("FAIL reset_m2r got %h want 0", MemToReg_out); end
    if (WriteReg_out !== 5'h0)  begin n_bad++; $display("FAIL reset_wr got %h want 0", WriteReg_out); end
    if (misaligned !== 1'b0)    begin n_bad++; $display("FAIL reset_mis got %h want 0", misaligned); end
    rst = 0;
  endtask

  task automatic test_store_load();
    drive(1, 0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 5'd0, 0, 0); tick();
    drive(1, 1, 0, 2'd2, 0, 32'h10, 32'h0, 1, 5'd7, 0, 0); tick();
    n_cmp += 3;
    if (ReadData !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_10 got %h want deadbeef", ReadData); end
    if (MemToReg_out !== 1'b1)     begin n_bad++; $display("FAIL lw_m2r got %h want 1", MemToReg_out); end
    if (WriteReg_out !== 5'd7)     begin n_bad++; $display("FAIL lw_wr got %h want 7", WriteReg_out); end
    drive(1, 1, 0, 2'd0, 1, 32'h13, 32'h0, 1, 5'd1, 0, 0); tick();
    n_cmp++;
    if (ReadData !== 32'hFFFFFFDE) begin n_bad++; $display("FAIL lb_13 got %h want ffffffde", ReadData); end
    drive(1, 1, 0, 2'd0, 0, 32'h13, 32'h0, 1, 5'd1, 0, 0); tick();
    n_cmp++;
    if (ReadData !== 32'h000000DE) begin n_bad++; $display("FAIL lbu_13 got %h want 000000de", ReadData); end
    drive(1, 1, 0, 2'd1, 1, 32'h12, 32'h0, 1, 5'd1, 0, 0); tick();
    n_cmp++;
    if (ReadData !== 32'hFFFFDEAD) begin n_bad++; $display("FAIL lh_12 got %h want ffffdead", ReadData); end
    drive(1, 0, 1, 2'd0, 0, 32'h11, 32'hAAAAAA55, 0, 5'd0, 0, 0); tick();
    n_cmp += 2;
    if (ReadData !== 32'h0)    begin n_bad++; $display("FAIL sb_rd got %h want 0", ReadData); end
    if (MemToReg_out !== 1'b0) begin n_bad++; $display("FAIL sb_m2r got %h want 0", MemToReg_out); end
    drive(1, 1, 0, 2'd2, 0, 32'h10, 32'h0, 1, 5'd2, 0, 0); tick();
    n_cmp++;
    if (ReadData !== 32'hDEAD55EF) begin n_bad++; $display("FAIL sb_merge got %h want dead55ef", ReadData); end
  endtask

  task automatic test_misaligned();
    drive(1, 1, 0, 2'd2, 0, 32'h12, 32'h0, 1, 5'd9, 0, 0); tick();
    n_cmp += 3;
    if (misaligned !== 1'b1)   begin n_bad++; $display("FAIL mis_pulse got %h want 1", misaligned); end
    if (RegWrite_out !== 1'b0) begin n_bad++; $display("FAIL mis_rw got %h want 0", RegWrite_out); end
    if (MemToReg_out !== 1'b0) begin n_bad++; $display("FAIL mis_m2r got %h want 0", MemToReg_out); end
    drive(1, 0, 1, 2'd2, 0, 32'h12, 32'hFFFFFFFF, 0, 5'd0, 0, 0); tick();
    n_cmp++;
    if (misaligned !== 1'b1) begin n_bad++; $display("FAIL mis_store got %h want 1", misaligned); end
    drive(1, 1, 0, 2'd2, 0, 32'h10, 32'h0, 1, 5'd2, 0, 0); tick();
    n_cmp += 2;
    if (misaligned !== 1'b0)       begin n_bad++; $display("FAIL mis_clear got %h want 0", misaligned); end
    if (ReadData !== 32'hDEAD55EF) begin n_bad++; $display("FAIL mis_nowrite got %h want dead55ef", ReadData); end
    // Fault under stall: pulse only when the instruction advances.
    drive(1, 1, 0, 2'd1, 0, 32'h11, 32'h0, 1, 5'd4, 1, 0); tick();
    n_cmp++;
    if (misaligned !== 1'b0) begin n_bad++; $display("FAIL mis_stalled got %h want 0", misaligned); end
    stall = 0; tick();
    n_cmp++;
    if (misaligned !== 1'b1) begin n_bad++; $display("FAIL mis_release got %h want 1", misaligned); end
  endtask

  task automatic test_stall_flush();
    drive(1, 0, 1, 2'd2, 0, 32'h20, 32'h11111111, 0, 5'd0, 0, 0); tick();
    drive(1, 0, 1, 2'd2, 0, 32'h24, 32'h22222222, 1, 5'd5, 1, 0);
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp += 3;
      if (ALUOut_q !== 32'h20)   begin n_bad++; $display("FAIL stall_hold_alu got %h want 20", ALUOut_q); end
      if (valid_out !== 1'b1)    begin n_bad++; $display("FAIL stall_hold_valid got %h want 1", valid_out); end
      if (RegWrite_out !== 1'b0) begin n_bad++; $display("FAIL stall_hold_rw got %h want 0", RegWrite_out); end
    end
    stall = 0; tick();
    n_cmp += 2;
    if (ALUOut_q !== 32'h24)   begin n_bad++; $display("FAIL stall_adv_alu got %h want 24", ALUOut_q); end
    if (RegWrite_out !== 1'b1) begin n_bad++; $display("FAIL stall_adv_rw got %h want 1", RegWrite_out); end
    drive(1, 1, 0, 2'd2, 0, 32'h24, 32'h0, 1, 5'd5, 0, 0); tick();
    n_cmp++;
    if (ReadData !== 32'h22222222) begin n_bad++; $display("FAIL stall_write got %h want 22222222", ReadData); end
    // Stalled store replaced by a load: the stalled cycle must not have written.
    drive(1, 0, 1, 2'd2, 0, 32'h20, 32'h33333333, 0, 5'd0, 1, 0); tick();
    drive(1, 1, 0, 2'd2, 0, 32'h20, 32'h0, 1, 5'd5, 0, 0); tick();
    n_cmp++;
    if (ReadData !== 32'h11111111) begin n_bad++; $display("FAIL stall_nowrite got %h want 11111111", ReadData); end
    drive(1, 0, 1, 2'd2, 0, 32'h20, 32'h44444444, 1, 5'd6, 1, 1); tick();
    n_cmp += 2;
    if (valid_out !== 1'b0)    begin n_bad++; $display("FAIL flush_valid got %h want 0", valid_out); end
    if (RegWrite_out !== 1'b0) begin n_bad++; $display("FAIL flush_rw got %h want 0", RegWrite_out); end
    drive(1, 1, 0, 2'd2, 0, 32'h20, 32'h0, 1, 5'd5, 0, 0); tick();
    n_cmp++;
    if (ReadData !== 32'h11111111) begin n_bad++; $display("FAIL flush_nowrite got %h want 11111111", ReadData); end
  endtask

  task automatic test_wrap_and_reset();
    drive(1, 0, 1, 2'd2, 0, 32'h400, 32'h12345678, 0, 5'd0, 0, 0); tick();
    drive(1, 1, 0, 2'd2, 0, 32'h0, 32'h0, 1, 5'd8, 0, 0); tick();
    n_cmp++;
    if (ReadData !== 32'h12345678) begin n_bad++; $display("FAIL wrap got %h want 12345678", ReadData); end
    rst = 1;
    drive(1, 0, 1, 2'd2, 0, 32'h0, 32'hCAFEF00D, 1, 5'd8, 0, 0); tick();
    n_cmp += 3;
    if (valid_out !== 1'b0)   begin n_bad++; $display("FAIL rstmid_valid got %h want 0", valid_out); end
    if (ALUOut_q !== 32'h0)   begin n_bad++; $display("FAIL rstmid_alu got %h want 0", ALUOut_q); end
    if (WriteReg_out !== 5'h0) begin n_bad++; $display("FAIL rstmid_wr got %h want 0", WriteReg_out); end
    rst = 0;
    drive(1, 1, 0, 2'd2, 0, 32'h0, 32'h0, 1, 5'd8, 0, 0); tick();
    n_cmp++;
    if (ReadData !== 32'h12345678) begin n_bad++; $display("FAIL rstmid_nowrite got %h want 12345678", ReadData); end
  endtask

  task automatic test_random();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 1, 2'd2, 0, 32'(i * 4), $urandom, 0, 5'd0, 0, 0);
      tick();
    end
    for (int c = 0; c < 1500; c++) begin
      int op = $urandom_range(0, 9);
      logic [1:0] sz = 2'($urandom_range(0, 3));
      logic [31:0] a = $urandom;
      if ($urandom_range(0, 9) < 7) a = a & ~32'(eff_bytes(sz) - 1);
      rst = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 9) != 0, op < 4, op >= 4 && op < 8, sz, 1'($urandom),
            a, $urandom, 1'($urandom), 5'($urandom), $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) == 0);
      tick();
      n_cmp += 5;
      if (valid_out !== e_valid)    begin n_bad++; $display("FAIL rnd_valid c=%0d got %h want %h", c, valid_out, e_valid); end
      if (RegWrite_out !== e_rw)    begin n_bad++; $display("FAIL rnd_rw c=%0d got %h want %h", c, RegWrite_out, e_rw); end
      if (MemToReg_out !== e_m2r)   begin n_bad++; $display("FAIL rnd_m2r c=%0d got %h want %h", c, MemToReg_out, e_m2r); end
      if (misaligned !== e_mis)     begin n_bad++; $display("FAIL rnd_mis c=%0d got %h want %h", c, misaligned, e_mis); end
      if (e_chk_alu && (ALUOut_q !== e_alu || WriteReg_out !== e_wr)) begin
        n_bad++; $display("FAIL rnd_alu c=%0d got %h/%h want %h/%h", c, ALUOut_q, WriteReg_out, e_alu, e_wr);
      end
      if (e_chk_rd) begin
        n_cmp++;
        if (ReadData !== e_rd) begin n_bad++; $display("FAIL rnd_rd c=%0d got %h want %h", c, ReadData, e_rd); end
      end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1;
    drive(0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 0, 5'd0, 0, 0);
    test_reset();
    test_store_load();
    test_misaligned();
    test_stall_flush();
    test_wrap_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
